// File: rtl/fc_layer_engine.sv
// Fully-connected layer stage: streams activations and weight rows from 1-cycle SRAMs, MACs, rescales, saturates, writes one result per neuron.
// Optional RELU_EN macro clamps negative results to zero (leave undefined for the logit layer).
module fc_layer_engine #(
  parameter int N_IN   = 784,
  parameter int N_OUT  = 100,
  parameter int DATA_W = 16,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 40,
  parameter int IN_AW  = 10,
  parameter int W_AW   = 18,
  parameter int OUT_AW = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [IN_AW-1:0]  in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic [W_AW-1:0]   w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic              out_we,
  output logic [OUT_AW-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  state_t                     state_q;
  logic                       busy_q, done_q, out_we_q, prod_vld_q;
  logic [IN_AW-1:0]           in_addr_q;
  logic [W_AW-1:0]            w_addr_q;
  logic [OUT_AW-1:0]          neuron_q, out_addr_q;
  logic [DATA_W-1:0]          out_data_q;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [2*DATA_W-1:0] in_ext, w_ext, prod;
  logic signed [ACC_W-1:0]    shifted;
  logic [DATA_W-1:0]          result;

  // SRAM data belongs to the address issued in the previous READ cycle.
  assign in_ext = {{DATA_W{in_data[DATA_W-1]}}, in_data};
  assign w_ext  = {{DATA_W{w_data[DATA_W-1]}}, w_data};
  assign prod   = in_ext * w_ext;

  always_comb begin
    acc_d = acc_q;
    if (prod_vld_q)
      acc_d = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  end

  always_comb begin
    shifted = acc_d >>> FRAC;
    result  = shifted[DATA_W-1:0];
    if (shifted > SAT_MAX)
      result = SAT_MAX[DATA_W-1:0];
    else if (shifted < SAT_MIN)
      result = SAT_MIN[DATA_W-1:0];
`ifdef RELU_EN
    if (shifted < 0)
      result = '0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      out_we_q   <= 1'b0;
      prod_vld_q <= 1'b0;
      in_addr_q  <= '0;
      w_addr_q   <= '0;
      neuron_q   <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
      acc_q      <= '0;
    end else begin
      prod_vld_q <= (state_q == S_READ);
      out_we_q   <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          acc_q <= '0;
          if (start) begin
            state_q   <= S_READ;
            busy_q    <= 1'b1;
            neuron_q  <= '0;
            in_addr_q <= '0;
            w_addr_q  <= '0;
          end
        end
        S_READ: begin
          acc_q    <= acc_d;
          w_addr_q <= w_addr_q + W_AW'(1);
          if (in_addr_q == IN_AW'(N_IN - 1))
            state_q <= S_DRAIN;
          else
            in_addr_q <= in_addr_q + IN_AW'(1);
        end
        S_DRAIN: begin
          acc_q      <= acc_d;
          out_we_q   <= 1'b1;
          out_addr_q <= neuron_q;
          out_data_q <= result;
          state_q    <= S_WRITE;
        end
        S_WRITE: begin
          acc_q     <= '0;
          in_addr_q <= '0;
          if (neuron_q == OUT_AW'(N_OUT - 1)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            neuron_q <= neuron_q + OUT_AW'(1);
            state_q  <= S_READ;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign in_addr   = in_addr_q;
  assign w_addr    = w_addr_q;
  assign out_we    = out_we_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign dbg_state = state_q;

endmodule
